// File: rtl/lcd_panel_mirror_if.sv
// LCD pin bundle between the host-side controller and the panel mirror.
// The host drives data/control; the mirror answers reads on lcd_rd_data.
interface lcd_panel_mirror_if;
  logic [7:0] lcd_data;
  logic [4:0] lcd_ctrl;     // [0]=EN [1]=RW [2]=RS [3]=ON [4]=BLON
  logic [7:0] lcd_rd_data;
  logic       lcd_rd_oe;

  modport master (output lcd_data, output lcd_ctrl, input lcd_rd_data, input lcd_rd_oe);
  modport slave  (input lcd_data, input lcd_ctrl, output lcd_rd_data, output lcd_rd_oe);
endinterface

// File: rtl/lcd_panel_mirror.sv
// HD44780-compatible responder (8-bit mode) that snoops the LCD pins,
// keeps an 80-byte DDRAM mirror plus display state, and exposes the
// mirror through a 1-cycle-latency read port.
module lcd_panel_mirror #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic                clock,
  input  logic                reset,
  lcd_panel_mirror_if.slave   lcd,
  input  logic [6:0]          rd_addr,
  output logic [7:0]          rd_data,
  output logic                busy,
  output logic [6:0]          addr_counter,
  output logic                display_on,
  output logic                cursor_on,
  output logic                blink_on,
  output logic                entry_inc,
  output logic                panel_on,
  output logic                backlight_on,
  output logic                wr_strobe,
  output logic                err_overrun,
  output logic                err_unsupported,
  input  logic                err_clr
);

  localparam int MAXC = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BUSY_LIM  = CW'(BUSY_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LIM = CW'(CLEAR_CYCLES - 1);
  localparam logic [7:0]    BLANK     = 8'h20;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEAR, ST_WAIT} state_t;

  // AC successor: the two DDRAM lines are 0x00-0x27 and 0x40-0x67.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
    logic [6:0] r;
    if (up) begin
      if (ac == 7'h27)      r = 7'h40;
      else if (ac == 7'h67) r = 7'h00;
      else                  r = ac + 7'd1;
    end else begin
      if (ac == 7'h00)      r = 7'h67;
      else if (ac == 7'h40) r = 7'h27;
      else                  r = ac - 7'd1;
    end
    return r;
  endfunction

  // Mirror index of a DDRAM address (line 2 follows line 1 at index 40).
  function automatic logic [6:0] ac_index(input logic [6:0] ac);
    return ac[6] ? ({1'b0, ac[5:0]} + 7'd40) : {1'b0, ac[5:0]};
  endfunction

  // Addresses past the end of a line snap to the start of that line.
  function automatic logic [6:0] ac_clamp(input logic [6:0] a);
    return (a[5:0] >= 6'h28) ? {a[6], 6'h00} : a;
  endfunction

  logic [7:0] data_s1_q, data_s2_q, data_s3_q;
  logic [4:0] ctrl_s1_q, ctrl_s2_q;
  logic [2:0] ctrl_s3_q;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, lim_q, lim_d;
  logic [6:0]      clr_idx_q, clr_idx_d, ac_q, ac_d;
  logic            cmd_rs_q, cmd_rs_d;
  logic [7:0]      cmd_data_q, cmd_data_d;
  logic            inc_q, inc_d, disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic            cgram_q, cgram_d, err_over_q, err_over_d, err_unsup_q, err_unsup_d;
  logic            wr_strobe_q, wr_strobe_d, busy_q, busy_d, rd_oe_q, rd_oe_d;
  logic [7:0]      lcd_rd_data_q, lcd_rd_data_d, rd_data_q, rd_data_d;
  logic [7:0]      mem_q [0:79];
  logic            mem_we, go_clear, en_fall;
  logic [6:0]      mem_waddr;
  logic [7:0]      mem_wdata;

  // Two-flop synchronizer on all pins, plus one extra stage for edge detect/capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_s1_q <= 8'h00; data_s2_q <= 8'h00; data_s3_q <= 8'h00;
      ctrl_s1_q <= 5'h00; ctrl_s2_q <= 5'h00; ctrl_s3_q <= 3'h0;
    end else begin
      data_s1_q <= lcd.lcd_data;  data_s2_q <= data_s1_q; data_s3_q <= data_s2_q;
      ctrl_s1_q <= lcd.lcd_ctrl;  ctrl_s2_q <= ctrl_s1_q; ctrl_s3_q <= ctrl_s2_q[2:0];
    end
  end

  // Transaction decode, instruction execution and busy sequencing.
  always_comb begin
    state_d = state_q;   cnt_d = cnt_q;   lim_d = lim_q;   clr_idx_d = clr_idx_q;
    cmd_rs_d = cmd_rs_q; cmd_data_d = cmd_data_q; ac_d = ac_q; inc_d = inc_q;
    disp_d = disp_q; cur_d = cur_q; blink_d = blink_q; cgram_d = cgram_q;
    err_over_d  = err_clr ? 1'b0 : err_over_q;
    err_unsup_d = err_clr ? 1'b0 : err_unsup_q;
    wr_strobe_d = 1'b0;  mem_we = 1'b0;  go_clear = 1'b0;
    mem_waddr = ac_index(ac_q);  mem_wdata = cmd_data_q;
    // stage 3 still holds the values from the last cycle EN was high
    en_fall = ctrl_s3_q[0] & ~ctrl_s2_q[0];

    if (en_fall) begin
      if (ctrl_s3_q[1]) begin
        ac_d = ctrl_s3_q[2] ? ac_step(ac_q, inc_q) : ac_q;
      end else if (state_q != ST_IDLE) begin
        err_over_d = 1'b1;
      end else begin
        cmd_rs_d = ctrl_s3_q[2]; cmd_data_d = data_s3_q;
        cnt_d = CW'(0); state_d = ST_EXEC;
      end
    end else begin
      ac_d = ac_q;
    end

    case (state_q)
      ST_IDLE: begin
      end
      ST_EXEC: begin
        cnt_d = cnt_q + CW'(1);
        lim_d = BUSY_LIM;
        if (cmd_rs_q) begin
          if (cgram_q) begin
            err_unsup_d = 1'b1;
          end else begin
            mem_we = 1'b1; wr_strobe_d = 1'b1; ac_d = ac_step(ac_q, inc_q);
          end
        end else begin
          casez (cmd_data_q)
            8'b1???????: begin cgram_d = 1'b0; ac_d = ac_clamp(cmd_data_q[6:0]); end
            8'b01??????: cgram_d = 1'b1;
            8'b001?????: err_unsup_d = err_unsup_d | ~cmd_data_q[4];
            8'b0001????: begin
              if (cmd_data_q[3]) err_unsup_d = 1'b1;
              else               ac_d = ac_step(ac_q, cmd_data_q[2]);
            end
            8'b00001???: {disp_d, cur_d, blink_d} = cmd_data_q[2:0];
            8'b000001??: begin inc_d = cmd_data_q[1]; err_unsup_d = err_unsup_d | cmd_data_q[0]; end
            8'b0000001?: begin ac_d = 7'h00; lim_d = CLEAR_LIM; end
            8'b00000001: begin ac_d = 7'h00; inc_d = 1'b1; lim_d = CLEAR_LIM; go_clear = 1'b1; end
            default:     lim_d = BUSY_LIM;
          endcase
        end
        if (go_clear) begin
          state_d = ST_CLEAR; clr_idx_d = 7'd0;
        end else if (cnt_q >= lim_d) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + CW'(1);
        mem_we = 1'b1; mem_waddr = clr_idx_q; mem_wdata = BLANK;
        clr_idx_d = clr_idx_q + 7'd1;
        if (clr_idx_q == 7'd79) state_d = (cnt_q >= lim_q) ? ST_IDLE : ST_WAIT;
        else                    state_d = ST_CLEAR;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_q >= lim_q) ? ST_IDLE : ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d        = (state_d != ST_IDLE);
    rd_oe_d       = ctrl_s2_q[0] & ctrl_s2_q[1];
    lcd_rd_data_d = ctrl_s2_q[2] ? mem_q[ac_index(ac_q)] : {busy_q, ac_q};
    rd_data_d     = (rd_addr > 7'd79) ? BLANK : mem_q[rd_addr];
  end

  // Control/state registers and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE; cnt_q <= CW'(0); lim_q <= CW'(0); clr_idx_q <= 7'd0;
      cmd_rs_q <= 1'b0; cmd_data_q <= 8'h00; ac_q <= 7'h00; inc_q <= 1'b1;
      disp_q <= 1'b0; cur_q <= 1'b0; blink_q <= 1'b0; cgram_q <= 1'b0;
      err_over_q <= 1'b0; err_unsup_q <= 1'b0; wr_strobe_q <= 1'b0; busy_q <= 1'b0;
      rd_oe_q <= 1'b0; lcd_rd_data_q <= 8'h00; rd_data_q <= BLANK;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; lim_q <= lim_d; clr_idx_q <= clr_idx_d;
      cmd_rs_q <= cmd_rs_d; cmd_data_q <= cmd_data_d; ac_q <= ac_d; inc_q <= inc_d;
      disp_q <= disp_d; cur_q <= cur_d; blink_q <= blink_d; cgram_q <= cgram_d;
      err_over_q <= err_over_d; err_unsup_q <= err_unsup_d; wr_strobe_q <= wr_strobe_d;
      busy_q <= busy_d; rd_oe_q <= rd_oe_d; lcd_rd_data_q <= lcd_rd_data_d; rd_data_q <= rd_data_d;
    end
  end

  // DDRAM mirror storage; reads above see the pre-write contents.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 80; i++) mem_q[i] <= BLANK;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_data         = rd_data_q;
  assign busy            = busy_q;
  assign addr_counter    = ac_q;
  assign display_on      = disp_q;
  assign cursor_on       = cur_q;
  assign blink_on        = blink_q;
  assign entry_inc       = inc_q;
  assign panel_on        = ctrl_s2_q[3];
  assign backlight_on    = ctrl_s2_q[4];
  assign wr_strobe       = wr_strobe_q;
  assign err_overrun     = err_over_q;
  assign err_unsupported = err_unsup_q;
  assign lcd.lcd_rd_data = lcd_rd_data_q;
  assign lcd.lcd_rd_oe   = rd_oe_q;

endmodule

// File: tb/tb_lcd_panel_mirror.sv
// Bench for lcd_panel_mirror: directed scenarios plus randomized traffic
// checked against a transaction-level model of the HD44780 rules.
module tb_lcd_panel_mirror;
  localparam int BUSY_N  = 60;
  localparam int CLEAR_N = 200;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  lcd_panel_mirror_if lcd();
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [6:0] addr_counter;
  logic busy, display_on, cursor_on, blink_on, entry_inc, panel_on, backlight_on;
  logic wr_strobe, err_overrun, err_unsupported, err_clr;

  lcd_panel_mirror #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
    .clock(clock), .reset(reset), .lcd(lcd.slave), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .addr_counter(addr_counter), .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .entry_inc(entry_inc), .panel_on(panel_on), .backlight_on(backlight_on),
    .wr_strobe(wr_strobe), .err_overrun(err_overrun), .err_unsupported(err_unsupported),
    .err_clr(err_clr));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_mem [80];
  int m_ac, m_strobes;
  bit m_inc, m_disp, m_cur, m_blink, m_cgram, m_unsup, m_over;

  function automatic int m_idx(input int a);
    return (a < 64) ? a : a - 64 + 40;
  endfunction

  function automatic int m_step(input int a, input bit up);
    if (up) return (a == 39) ? 64 : (a == 103) ? 0 : a + 1;
    else    return (a == 0) ? 103 : (a == 64) ? 39 : a - 1;
  endfunction

  task automatic m_reset();
    foreach (m_mem[i]) m_mem[i] = 8'h20;
    m_ac = 0; m_inc = 1; m_disp = 0; m_cur = 0; m_blink = 0;
    m_cgram = 0; m_unsup = 0; m_over = 0;
  endtask

  task automatic m_instr(input logic [7:0] d);
    int a;
    if (d >= 128) begin
      m_cgram = 0; a = d & 127;
      if ((a & 63) >= 40) a = a & 64;
      m_ac = a;
    end
    else if (d >= 64) m_cgram = 1;
    else if (d >= 32) begin if (!d[4]) m_unsup = 1; end
    else if (d >= 16) begin if (d[3]) m_unsup = 1; else m_ac = m_step(m_ac, d[2]); end
    else if (d >= 8)  begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
    else if (d >= 4)  begin m_inc = d[1]; if (d[0]) m_unsup = 1; end
    else if (d >= 2)  m_ac = 0;
    else if (d == 1)  begin m_ac = 0; m_inc = 1; foreach (m_mem[i]) m_mem[i] = 8'h20; end
  endtask

  task automatic m_data(input logic [7:0] d);
    if (m_cgram) m_unsup = 1;
    else begin m_mem[m_idx(m_ac)] = d; m_ac = m_step(m_ac, m_inc); m_strobes++; end
  endtask

  // ---------------- observers ----------------
  int busy_run = 0, last_run = 0, strobe_cnt = 0;
  always @(negedge clock) begin
    if (busy) busy_run <= busy_run + 1;
    else if (busy_run != 0) begin last_run <= busy_run; busy_run <= 0; end
  end
  always @(negedge clock) if (wr_strobe) strobe_cnt <= strobe_cnt + 1;

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic lcd_write(input bit rs, input logic [7:0] d);
    lcd.lcd_data = d;
    lcd.lcd_ctrl = {1'b1, 1'b1, rs, 1'b0, 1'b1};
    tick(3);
    lcd.lcd_ctrl[0] = 1'b0;
    tick(3);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin tick(1); n++; end
    check("busy_timeout", {31'd0, busy}, 32'd0);
    tick(1);
  endtask

  task automatic do_instr(input logic [7:0] d);
    lcd_write(1'b0, d); m_instr(d); wait_idle();
  endtask

  task automatic do_data(input logic [7:0] d);
    lcd_write(1'b1, d); m_data(d); wait_idle();
  endtask

  task automatic lcd_read(input bit rs, output logic [7:0] val, output logic oe_mid, output logic oe_after);
    lcd.lcd_ctrl = {1'b1, 1'b1, rs, 1'b1, 1'b1};
    tick(4);
    val = lcd.lcd_rd_data; oe_mid = lcd.lcd_rd_oe;
    lcd.lcd_ctrl[0] = 1'b0;
    tick(4);
    oe_after = lcd.lcd_rd_oe;
    lcd.lcd_ctrl[1] = 1'b0;
  endtask

  task automatic read_mirror(input int idx, output logic [7:0] val);
    rd_addr = 7'(idx);
    tick(1);
    val = rd_data;
  endtask

  task automatic check_mirror_all(input string tag);
    logic [7:0] v;
    for (int i = 0; i < 80; i++) begin
      read_mirror(i, v);
      check($sformatf("%s[%0d]", tag, i), {24'd0, v}, {24'd0, m_mem[i]});
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ac"}, {25'd0, addr_counter}, m_ac);
    check({tag, "_inc"}, {31'd0, entry_inc}, {31'd0, m_inc});
    check({tag, "_dcb"}, {29'd0, display_on, cursor_on, blink_on}, {29'd0, m_disp, m_cur, m_blink});
    check({tag, "_unsup"}, {31'd0, err_unsupported}, {31'd0, m_unsup});
    check({tag, "_over"}, {31'd0, err_overrun}, {31'd0, m_over});
  endtask

  task automatic fill_mirror();
    do_instr(8'h80);
    do_instr(8'h06);
    for (int i = 0; i < 80; i++) do_data(8'($urandom_range(33, 126)));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] v;
    logic oe_m, oe_a;
    int s0, r;

    lcd.lcd_data = 8'h00; lcd.lcd_ctrl = 5'h00; rd_addr = 7'd0; err_clr = 1'b0;
    m_reset(); m_strobes = 0;
    tick(3);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ac", {25'd0, addr_counter}, 32'd0);
    check("rst_inc", {31'd0, entry_inc}, 32'd1);
    check("rst_dcb", {29'd0, display_on, cursor_on, blink_on}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'h20);
    check("rst_lcd_rd", {23'd0, lcd.lcd_rd_oe, lcd.lcd_rd_data}, 32'd0);
    check("rst_flags", {28'd0, err_overrun, err_unsupported, wr_strobe, panel_on}, 32'd0);
    reset = 1'b1;
    tick(2);

    // init sequence and "Wel"
    do_instr(8'h38);
    check("busy_len_normal", last_run, BUSY_N);
    do_instr(8'h0C); do_instr(8'h01); do_instr(8'h06); do_instr(8'h80);
    s0 = strobe_cnt;
    do_data(8'h57); do_data(8'h65); do_data(8'h6C);
    check("wel_disp", {31'd0, display_on}, 32'd1);
    check("wel_ac", {25'd0, addr_counter}, 32'h03);
    check("wel_strobes", strobe_cnt - s0, 32'd3);
    read_mirror(0, v); check("wel_m0", {24'd0, v}, 32'h57);
    read_mirror(1, v); check("wel_m1", {24'd0, v}, 32'h65);
    read_mirror(2, v); check("wel_m2", {24'd0, v}, 32'h6C);
    read_mirror(3, v); check("wel_m3", {24'd0, v}, 32'h20);
    read_mirror(100, v); check("idx_oob", {24'd0, v}, 32'h20);
    check("pins_on", {30'd0, panel_on, backlight_on}, 32'd3);
    check_state("wel");

    // host reads: data read at AC=0, status read while busy
    do_instr(8'h80);
    lcd_read(1'b1, v, oe_m, oe_a);
    check("rd_data_w", {24'd0, v}, 32'h57);
    m_ac = m_step(m_ac, m_inc);
    check("rd_data_ac", {25'd0, addr_counter}, m_ac);
    check("rd_oe_mid", {31'd0, oe_m}, 32'd1);
    lcd_write(1'b0, 8'h85); m_instr(8'h85);
    check("busy_during", {31'd0, busy}, 32'd1);
    lcd_read(1'b0, v, oe_m, oe_a);
    check("rd_status_busy", {24'd0, v}, 32'h80 | m_ac);
    check("rd_oe_mid2", {31'd0, oe_m}, 32'd1);
    check("rd_oe_after", {31'd0, oe_a}, 32'd0);
    wait_idle();
    lcd_read(1'b0, v, oe_m, oe_a);
    check("rd_status_idle", {24'd0, v}, m_ac);

    // line wrap in both directions
    do_instr(8'hA7);
    check("clamp_ac", {25'd0, addr_counter}, 32'h27);
    do_data(8'h41);
    read_mirror(39, v); check("wrap_m39", {24'd0, v}, 32'h41);
    check("wrap_ac40", {25'd0, addr_counter}, 32'h40);
    do_data(8'h41);
    read_mirror(40, v); check("wrap_m40", {24'd0, v}, 32'h41);
    do_instr(8'h04); do_instr(8'h80); do_data(8'h33);
    check("dec_wrap_67", {25'd0, addr_counter}, 32'h67);
    do_instr(8'hC0); do_data(8'h34);
    check("dec_wrap_27", {25'd0, addr_counter}, 32'h27);
    do_instr(8'h06);

    // overrun: second write lands while busy
    lcd_write(1'b1, 8'h58); m_data(8'h58);
    tick(4);
    lcd_write(1'b1, 8'h59); m_over = 1;
    check("overrun_set", {31'd0, err_overrun}, 32'd1);
    wait_idle();
    check_state("overrun");
    err_clr = 1'b1; tick(1); err_clr = 1'b0; m_over = 0; tick(1);
    check("overrun_clr", {31'd0, err_overrun}, 32'd0);

    // CGRAM data write is discarded and flagged
    s0 = strobe_cnt;
    do_instr(8'h40); do_data(8'h55);
    check("cgram_unsup", {31'd0, err_unsupported}, 32'd1);
    check("cgram_nostrobe", strobe_cnt - s0, 32'd0);
    do_instr(8'h80);
    check_mirror_all("pre_fill");
    err_clr = 1'b1; tick(1); err_clr = 1'b0; m_unsup = 0; tick(1);

    // clear with a full mirror
    fill_mirror();
    check_mirror_all("fill");
    do_instr(8'h01);
    check("busy_len_clear", last_run, CLEAR_N);
    check_mirror_all("cleared");
    check_state("cleared");

    // randomized traffic
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: do_data(8'($urandom_range(0, 255)));
        4: do_instr(8'h80 | 8'($urandom_range(0, 127)));
        5: do_instr(8'h04 | 8'($urandom_range(0, 3)));
        6: do_instr(8'h10 | 8'($urandom_range(0, 15)));
        7: do_instr(8'h08 | 8'($urandom_range(0, 7)));
        8: begin
          lcd_read(1'b1, v, oe_m, oe_a);
          check("rnd_rd", {24'd0, v}, {24'd0, m_mem[m_idx(m_ac)]});
          m_ac = m_step(m_ac, m_inc);
        end
        default: do_instr(8'h40 | 8'($urandom_range(0, 63)));
      endcase
      check("rnd_ac", {25'd0, addr_counter}, m_ac);
    end
    check_mirror_all("rnd");
    check_state("rnd");
    check("rnd_strobes", strobe_cnt, m_strobes);

    // reset in the middle of a clear
    do_instr(8'h80);
    fill_mirror();
    lcd_write(1'b0, 8'h01);
    tick(20);
    check("mid_clear_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_ac", {25'd0, addr_counter}, 32'd0);
    m_reset();
    tick(2);
    reset = 1'b1;
    tick(2);
    check("rst_mid_idle", {31'd0, busy}, 32'd0);
    check_mirror_all("rst_mid");
    check_state("rst_mid");
    do_instr(8'h28);
    check("dl0_unsup", {31'd0, err_unsupported}, 32'd1);
    check("final_strobes", strobe_cnt, m_strobes);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
